// File: rtl/counter_syn_sched.sv
// Round-robin scheduler that shares one bus-synchronizer channel among NUM_REQ requesters.
// The winner's word is held for HOLD_CYCLES clocks and tagged by a toggle. An ack is sent when the hold ends.
module counter_syn_sched #(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 4,
    parameter int ID_WIDTH    = 2,
    parameter int HOLD_CYCLES = 6
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic                           i_en,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   i_data,
    output logic [NUM_REQ-1:0]             o_ack,
    output logic                           o_busy,
    output logic [BUS_WIDTH-1:0]           o_syn_data,
    output logic [ID_WIDTH-1:0]            o_syn_id,
    output logic                           o_syn_tgl
);

    localparam int                  CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0] PTR_RST  = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [0:0]          ST_IDLE  = 1'b0;
    localparam logic [0:0]          ST_HOLD  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic                 tgl_q, tgl_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic [BUS_WIDTH-1:0] req_word [NUM_REQ];
    logic [NUM_REQ-1:0]   above_ptr;
    logic [NUM_REQ-1:0]   req_above;
    logic [ID_WIDTH-1:0]  win_above;
    logic [ID_WIDTH-1:0]  win_any;
    logic [ID_WIDTH-1:0]  winner;
    logic                 hit_above;
    logic                 req_any;
    logic                 start;
    logic                 hold_done;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi]  = i_data[gi*BUS_WIDTH +: BUS_WIDTH];
            assign above_ptr[gi] = (ID_WIDTH'(gi) > ptr_q);
            assign ack_d[gi]     = hold_done && (ptr_q == ID_WIDTH'(gi));
        end
    endgenerate

    // Round-robin: lowest request above the last grant wins, else wrap to the lowest request overall.
    assign req_above = i_req & above_ptr;
    assign hit_above = |req_above;
    assign req_any   = |i_req;

    always_comb begin
        win_above = '0;
        win_any   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_above[k]) begin
                win_above = ID_WIDTH'(k);
            end
            if (i_req[k]) begin
                win_any = ID_WIDTH'(k);
            end
        end
    end

    assign winner    = hit_above ? win_above : win_any;
    assign start     = (state_q == ST_IDLE) && i_en && req_any;
    assign hold_done = (state_q == ST_HOLD) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        tgl_d   = tgl_q;
        busy_d  = busy_q;
        if (start) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
            ptr_d   = winner;
            data_d  = req_word[winner];
            id_d    = winner;
            tgl_d   = ~tgl_q;
            busy_d  = 1'b1;
        end else if (hold_done) begin
            // The following IDLE cycle is mandatory, which keeps the ack and the next capture apart.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else if (state_q == ST_HOLD) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_RST;
            data_q  <= '0;
            id_q    <= '0;
            tgl_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            tgl_q   <= tgl_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
    assign o_syn_data = data_q;
    assign o_syn_id   = id_q;
    assign o_syn_tgl  = tgl_q;

endmodule

// File: tb/tb_counter_syn_sched.sv
// Bench for counter_syn_sched: a default instance (4 requesters, hold 6) and a minimum-hold instance (3, hold 2).
// Each step is compared against a transaction-level model that tracks the time since the last capture.
module tb_counter_syn_sched;

    localparam int NA = 4;
    localparam int HA = 6;
    localparam int NB = 3;
    localparam int HB = 2;

    typedef struct {
        int         age;
        bit         active;
        int         ptr;
        logic [3:0] data;
        int         id;
        bit         tgl;
        logic [3:0] ack;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        en_a, en_b;
    logic [3:0]  req_a;
    logic [2:0]  req_b;
    logic [15:0] data_a;
    logic [11:0] data_b;
    logic [3:0]  ack_a;
    logic [2:0]  ack_b;
    logic        busy_a, busy_b, tgl_a, tgl_b;
    logic [3:0]  sd_a, sd_b;
    logic [1:0]  sid_a, sid_b;

    model_t ma, mb;
    int n_checks = 0;
    int n_pass   = 0;

    counter_syn_sched #(.NUM_REQ(NA), .BUS_WIDTH(4), .ID_WIDTH(2), .HOLD_CYCLES(HA)) u_dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_en(en_a), .i_req(req_a), .i_data(data_a),
        .o_ack(ack_a), .o_busy(busy_a), .o_syn_data(sd_a), .o_syn_id(sid_a), .o_syn_tgl(tgl_a)
    );

    counter_syn_sched #(.NUM_REQ(NB), .BUS_WIDTH(4), .ID_WIDTH(2), .HOLD_CYCLES(HB)) u_dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_en(en_b), .i_req(req_b), .i_data(data_b),
        .o_ack(ack_b), .o_busy(busy_b), .o_syn_data(sd_b), .o_syn_id(sid_b), .o_syn_tgl(tgl_b)
    );

    function automatic model_t mreset(int n);
        model_t r;
        r.age = 0; r.active = 0; r.ptr = n - 1; r.data = '0;
        r.id = 0; r.tgl = 0; r.ack = '0;
        return r;
    endfunction

    // A capture starts a transfer of age 0. The ack arrives on the edge where the age reaches the hold length.
    function automatic model_t mstep(model_t m, int n, int h, bit en, logic [3:0] req, logic [15:0] data);
        model_t r;
        int     w;
        bit     found;
        r = m;
        r.ack = '0;
        found = 0;
        if (m.active) begin
            r.age = m.age + 1;
            if (r.age == h) begin
                r.ack[m.id] = 1'b1;
                r.active = 0;
            end
        end else if (en) begin
            for (int k = 1; k <= n; k++) begin
                w = (m.ptr + k) % n;
                if (!found && req[w] === 1'b1) begin
                    found = 1;
                    r.data = data[w*4 +: 4];
                    r.id = w;
                    r.ptr = w;
                    r.tgl = ~m.tgl;
                    r.active = 1;
                    r.age = 0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] obs_a();
        return {4'b0, ack_a, busy_a, sd_a, sid_a, tgl_a};
    endfunction
    function automatic logic [15:0] exp_a();
        return {4'b0, ma.ack, ma.active, ma.data, 2'(ma.id), ma.tgl};
    endfunction
    function automatic logic [15:0] obs_b();
        return {5'b0, ack_b, busy_b, sd_b, sid_b, tgl_b};
    endfunction
    function automatic logic [15:0] exp_b();
        return {5'b0, mb.ack[2:0], mb.active, mb.data, 2'(mb.id), mb.tgl};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rstn) begin
            ma = mreset(NA);
            mb = mreset(NB);
        end else begin
            ma = mstep(ma, NA, HA, en_a, req_a, data_a);
            mb = mstep(mb, NB, HB, en_b, {1'b0, req_b}, {4'b0, data_b});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        en_a = 0; req_a = '0; data_a = '0;
        en_b = 0; req_b = '0; data_b = '0;
        rstn = 0;
        ma = mreset(NA);
        mb = mreset(NB);
        tick();
        tick();
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs_a() !== 16'h0000) $display("FAIL reset_a: got %h expected %h", obs_a(), 16'h0000);
        else n_pass++;
        n_checks++;
        if (obs_b() !== 16'h0000) $display("FAIL reset_b: got %h expected %h", obs_b(), 16'h0000);
        else n_pass++;
        tick();
        n_checks++;
        if (obs_a() !== exp_a()) $display("FAIL reset_idle: got %h expected %h", obs_a(), exp_a());
        else n_pass++;
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        int ack_at = -1;
        do_reset();
        data_a = 16'h000A; req_a = 4'b0001; en_a = 1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL single cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            if (busy_a === 1'b1) busy_cnt++;
            if (ack_a === 4'b0001 && ack_at < 0) ack_at = c;
            if (ma.ack != 0) req_a = req_a & ~ma.ack;
        end
        n_checks++;
        if (busy_cnt !== 6) $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, 6);
        else n_pass++;
        n_checks++;
        if (ack_at !== 7) $display("FAIL single_ack_cycle: got %0d expected %0d", ack_at, 7);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int   ids[$];
        int   cyc[$];
        int   exp_ids[5] = '{0, 1, 2, 3, 0};
        logic prev;
        do_reset();
        data_a = 16'h4321; req_a = 4'b1111; en_a = 1;
        for (int c = 1; c <= 38; c++) begin
            if (c == 31) begin req_a = '0; en_a = 0; end
            prev = tgl_a;
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL round_robin cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            if (tgl_a !== prev) begin ids.push_back(int'(sid_a)); cyc.push_back(c); end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= ids.size() || ids[i] !== exp_ids[i])
                $display("FAIL rr_id[%0d]: got %0d expected %0d", i, (i < ids.size()) ? ids[i] : -1, exp_ids[i]);
            else n_pass++;
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (i >= cyc.size() || cyc[i] - cyc[i-1] !== 7)
                $display("FAIL rr_spacing[%0d]: got %0d expected %0d", i, (i < cyc.size()) ? cyc[i] - cyc[i-1] : -1, 7);
            else n_pass++;
        end
    endtask

    task automatic test_enable_gating();
        bit   saw_busy = 0;
        int   ack_at = -1;
        logic tgl_cap;
        do_reset();
        en_a = 0; req_a = 4'b0100; data_a = 16'h0B00;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL gate_off cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            if (busy_a !== 1'b0) saw_busy = 1;
        end
        n_checks++;
        if (saw_busy) $display("FAIL gate_no_busy: got busy 1 expected busy 0");
        else n_pass++;
        en_a = 1;
        tick();
        n_checks++;
        if (sid_a !== 2'd2 || busy_a !== 1'b1) $display("FAIL gate_capture: got id %0d busy %b expected id 2 busy 1", sid_a, busy_a);
        else n_pass++;
        tgl_cap = tgl_a;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) en_a = 0;
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL gate_hold cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            if (ack_a === 4'b0100 && ack_at < 0) ack_at = c;
        end
        n_checks++;
        if (ack_at !== 6) $display("FAIL gate_ack_cycle: got %0d expected %0d", ack_at, 6);
        else n_pass++;
        n_checks++;
        if (tgl_a !== tgl_cap || busy_a !== 1'b0) $display("FAIL gate_no_regrant: got tgl %b busy %b expected tgl %b busy 0", tgl_a, busy_a, tgl_cap);
        else n_pass++;
    endtask

    task automatic test_req_drop();
        bit held = 1;
        bit saw_ack = 0;
        do_reset();
        en_a = 1; req_a = 4'b0010; data_a = 16'h0050;
        tick();
        n_checks++;
        if (obs_a() !== exp_a()) $display("FAIL drop_capture: got %h expected %h", obs_a(), exp_a());
        else n_pass++;
        req_a = '0; data_a = 16'h00F0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL drop cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            if (sd_a !== 4'h5) held = 0;
            if (c == 6 && ack_a === 4'b0010) saw_ack = 1;
        end
        n_checks++;
        if (!held || !saw_ack) $display("FAIL drop_hold_ack: got held %b ack %b expected held 1 ack 1", held, saw_ack);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        bit saw_ack = 0;
        do_reset();
        en_a = 1; req_a = 4'b0010; data_a = 16'h00C0;
        tick();
        tick();
        tick();
        #2;
        rstn = 0;
        ma = mreset(NA);
        mb = mreset(NB);
        #1;
        n_checks++;
        if (obs_a() !== 16'h0000) $display("FAIL async_reset: got %h expected %h", obs_a(), 16'h0000);
        else n_pass++;
        tick();
        n_checks++;
        if (obs_a() !== exp_a()) $display("FAIL reset_held: got %h expected %h", obs_a(), exp_a());
        else n_pass++;
        rstn = 1; req_a = 4'b1010; data_a = 16'h7060;
        tick();
        n_checks++;
        if (sid_a !== 2'd1 || sd_a !== 4'h6) $display("FAIL reset_ptr: got id %0d data %h expected id 1 data 6", sid_a, sd_a);
        else n_pass++;
        for (int c = 1; c <= 15; c++) begin
            if (ma.ack != 0) req_a = req_a & ~ma.ack;
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL post_reset cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            if (ack_a !== 4'b0000 && c < 6) saw_ack = 1;
        end
        n_checks++;
        if (saw_ack) $display("FAIL reset_spurious_ack: got early ack expected none");
        else n_pass++;
        en_a = 0; req_a = '0;
    endtask

    task automatic test_min_hold();
        int   ids[$];
        int   cyc[$];
        int   acks[$];
        int   exp_ids[4] = '{0, 1, 2, 0};
        logic prev;
        do_reset();
        en_b = 1; req_b = 3'b111; data_b = 12'h987;
        for (int c = 1; c <= 14; c++) begin
            if (c == 11) begin en_b = 0; req_b = '0; end
            prev = tgl_b;
            tick();
            n_checks++;
            if (obs_b() !== exp_b()) $display("FAIL min_hold cyc %0d: got %h expected %h", c, obs_b(), exp_b());
            else n_pass++;
            if (tgl_b !== prev) begin ids.push_back(int'(sid_b)); cyc.push_back(c); end
            if (ack_b !== 3'b000) acks.push_back(c);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= ids.size() || ids[i] !== exp_ids[i] || cyc[i] !== 1 + 3 * i)
                $display("FAIL min_hold_capture[%0d]: got id %0d cyc %0d expected id %0d cyc %0d", i,
                         (i < ids.size()) ? ids[i] : -1, (i < cyc.size()) ? cyc[i] : -1, exp_ids[i], 1 + 3 * i);
            else n_pass++;
            n_checks++;
            if (i >= acks.size() || acks[i] !== 3 + 3 * i)
                $display("FAIL min_hold_ack[%0d]: got cyc %0d expected cyc %0d", i, (i < acks.size()) ? acks[i] : -1, 3 + 3 * i);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en_a   = ($urandom_range(0, 7) != 0);
            req_a  = 4'($urandom_range(0, 15));
            data_a = 16'($urandom());
            en_b   = ($urandom_range(0, 7) != 0);
            req_b  = 3'($urandom_range(0, 7));
            data_b = 12'($urandom());
            tick();
            n_checks++;
            if (obs_a() !== exp_a()) $display("FAIL random_a cyc %0d: got %h expected %h", c, obs_a(), exp_a());
            else n_pass++;
            n_checks++;
            if (obs_b() !== exp_b()) $display("FAIL random_b cyc %0d: got %h expected %h", c, obs_b(), exp_b());
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 0;
        en_a = 0; req_a = '0; data_a = '0;
        en_b = 0; req_b = '0; data_b = '0;
        ma = mreset(NA);
        mb = mreset(NB);
        test_reset();
        test_single();
        test_round_robin();
        test_enable_gating();
        test_req_drop();
        test_reset_mid_hold();
        test_min_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
